// File: rtl/crypto_pkg.sv
// Shared constants, state encoding and byte helper for the chained-XOR word cipher.
package crypto_pkg;

    localparam logic [7:0]  CRYPTO_IV        = 8'h9B;
    localparam int unsigned CRYPTO_NUM_BYTES = 4;
    localparam int unsigned WORD_W           = 8 * CRYPTO_NUM_BYTES;

    localparam logic MODE_CCHAIN = 1'b0;
    localparam logic MODE_PCHAIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        DONE = 2'd2
    } dec_state_t;

    // Byte i lives at bits [8i+7:8i].
    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] word,
                                            input int unsigned idx);
        return 8'(word >> (8 * idx));
    endfunction

endpackage

// File: rtl/crypto_byte_dec.sv
// Single-byte decrypt slice: plaintext = ciphertext ^ key ^ chaining byte.
module crypto_byte_dec (
    input  logic [7:0] i_c,
    input  logic [7:0] i_k,
    input  logic [7:0] i_chain,
    output logic [7:0] o_p
);

    assign o_p = i_c ^ i_k ^ i_chain;

endmodule

// File: rtl/cryptography_decoder.sv
// Byte-serial decryptor: captures one ciphertext word, recovers one byte per clock
// LSB first, then presents the plaintext word on a valid/ready output.
module cryptography_decoder
    import crypto_pkg::*;
#(
    parameter logic [7:0]  IV        = CRYPTO_IV,
    parameter int unsigned NUM_BYTES = CRYPTO_NUM_BYTES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic [8*NUM_BYTES-1:0] in_key,
    input  logic                   in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data
);

    localparam int unsigned CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - 1);

    dec_state_t              r_state;
    logic [CW-1:0]           r_cnt;
    logic [8*NUM_BYTES-1:0]  r_c;
    logic [8*NUM_BYTES-1:0]  r_k;
    logic                    r_sel;
    logic [8*NUM_BYTES-1:0]  r_acc;
    logic                    r_out_valid;
    logic [8*NUM_BYTES-1:0]  r_out_data;

    logic [CW-1:0]           w_cnt_prev;
    logic [7:0]              w_c_cur;
    logic [7:0]              w_k_cur;
    logic [7:0]              w_c_prev;
    logic [7:0]              w_p_prev;
    logic [7:0]              w_chain;
    logic [7:0]              w_p;
    logic [8*NUM_BYTES-1:0]  w_acc_next;
    logic                    w_accept;

    assign in_ready  = ~rst & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    // Wraps at cnt = 0, but the previous-byte values are unused there.
    assign w_cnt_prev = r_cnt - 1'b1;
    assign w_c_cur    = get_byte(r_c, 32'(r_cnt));
    assign w_k_cur    = get_byte(r_k, 32'(r_cnt));
    assign w_c_prev   = get_byte(r_c, 32'(w_cnt_prev));
    assign w_p_prev   = get_byte(r_acc, 32'(w_cnt_prev));

    always_comb begin
        w_chain = w_c_prev;
        if (r_cnt == '0) begin
            w_chain = IV;
        end else if (r_sel == MODE_PCHAIN) begin
            w_chain = w_p_prev;
        end
    end

    crypto_byte_dec u_byte_dec (
        .i_c     (w_c_cur),
        .i_k     (w_k_cur),
        .i_chain (w_chain),
        .o_p     (w_p)
    );

    always_comb begin
        w_acc_next = r_acc;
        for (int i = 0; i < int'(NUM_BYTES); i++) begin
            if (r_cnt == CW'(i)) begin
                w_acc_next[8*i +: 8] = w_p;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_c         <= '0;
            r_k         <= '0;
            r_sel       <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_c     <= in_data;
                        r_k     <= in_key;
                        r_sel   <= in_sel;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= DEC;
                    end
                end
                DEC: begin
                    r_acc <= w_acc_next;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_acc_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_c     <= in_data;
                            r_k     <= in_key;
                            r_sel   <= in_sel;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= DEC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cryptography_decoder.sv
// Directed and loopback checks for cryptography_decoder.
module tb_cryptography_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_key;
    logic        in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_chk;
    int n_err;

    cryptography_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Golden encryptor: chain is the previous ciphertext (sel=0) or plaintext (sel=1) byte.
    function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [31:0] k,
                                            input logic sel);
        logic [7:0]  prev;
        logic [7:0]  cb;
        logic [31:0] c;
        prev = 8'h9B;
        c    = '0;
        for (int i = 0; i < 4; i++) begin
            cb           = p[8*i +: 8] ^ k[8*i +: 8] ^ prev;
            c[8*i +: 8]  = cb;
            prev         = sel ? p[8*i +: 8] : cb;
        end
        return c;
    endfunction

    // Accept a word from IDLE, scramble inputs during DEC, check latency and result.
    task automatic run_word(input logic [31:0] c, input logic [31:0] k, input logic sel,
                            input logic [31:0] exp, input string tag);
        in_data  = c;
        in_key   = k;
        in_sel   = sel;
        in_valid = 1'b1;
        chk(32'(in_ready), 32'd1, {tag, "_in_ready_idle"});
        tick();
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        in_key   = 32'hA5A5_5A5A;
        in_sel   = ~sel;
        chk(32'(in_ready), 32'd0, {tag, "_in_ready_dec"});
        for (int i = 0; i < 3; i++) begin
            chk(32'(out_valid), 32'd0, {tag, "_early_valid"});
            tick();
        end
        chk(32'(out_valid), 32'd0, {tag, "_early_valid"});
        tick();
        chk(32'(out_valid), 32'd1, {tag, "_valid_t5"});
        chk(out_data, exp, {tag, "_data"});
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk(32'(out_valid), 32'd0, {tag, "_valid_drop"});
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] p;
        logic [31:0] k;
        logic [31:0] c;
        logic        s;
        logic        seen;
        int          budget;

        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_sel    = 1'b0;
        out_ready = 1'b0;

        tick();
        tick();
        chk(32'(in_ready), 32'd0, "reset_in_ready");
        chk(32'(out_valid), 32'd0, "reset_out_valid");
        chk(out_data, 32'h0, "reset_out_data");
        rst = 1'b0;
        #1;
        chk(32'(in_ready), 32'd1, "idle_in_ready");

        run_word(32'h9B9B9B9B, 32'h0, 1'b0, 32'h00000000, "cchain_iv");
        drain("cchain_iv");
        run_word(32'h9B9B9B9B, 32'h0, 1'b1, 32'h9B009B00, "pchain_iv");
        drain("pchain_iv");
        run_word(32'h12345678, 32'h11111111, 1'b0, 32'h37733FF2, "cchain_key");
        drain("cchain_key");

        // Stall: c=0, k=0, sel=0 decrypts to 0000009B.
        run_word(32'h0, 32'h0, 1'b0, 32'h0000009B, "stall");
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk(32'(out_valid), 32'd1, "stall_valid");
            chk(out_data, held, "stall_data");
            chk(32'(in_ready), 32'd0, "stall_in_ready");
        end

        // Back-to-back: output handshake and new accept in the same cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h9B9B9B9B;
        in_key    = 32'h0;
        in_sel    = 1'b1;
        #1;
        chk(32'(in_ready), 32'd1, "b2b_in_ready");
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_sel    = 1'b0;
        chk(32'(in_ready), 32'd0, "b2b_in_ready_dec");
        tick();
        tick();
        tick();
        tick();
        chk(32'(out_valid), 32'd1, "b2b_valid_t5");
        chk(out_data, 32'h9B009B00, "b2b_data");
        drain("b2b");

        // Reset while cnt = 2.
        in_data  = 32'h12345678;
        in_key   = 32'h11111111;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk(32'(in_ready), 32'd0, "midrst_in_ready");
        tick();
        chk(32'(out_valid), 32'd0, "midrst_out_valid");
        chk(out_data, 32'h0, "midrst_out_data");
        rst = 1'b0;
        #1;
        chk(32'(in_ready), 32'd1, "midrst_idle");
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk(32'(seen), 32'd0, "midrst_no_output");

        // Loopback through the golden encryptor.
        for (int n = 0; n < 1000; n++) begin
            p = $urandom();
            k = $urandom();
            s = 1'($urandom_range(0, 1));
            c = encrypt(p, k, s);
            in_data  = c;
            in_key   = k;
            in_sel   = s;
            in_valid = 1'b1;
            budget   = 0;
            while (in_ready !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            tick();
            in_valid = 1'b0;
            budget   = 0;
            while (out_valid !== 1'b1 && budget < 20) begin
                tick();
                budget++;
            end
            if (budget >= 20) begin
                chk(32'(out_valid), 32'd1, "loop_timeout");
            end else begin
                chk(out_data, p, "loopback");
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
